// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshaking on both sides.
// S1 captures operands and op; S2 holds the computed result together with
// its zero flag, parity and the op that produced it. The stages form a
// two-entry elastic buffer: capacity is two beats, and throughput is one
// beat per cycle while the consumer keeps out_ready high.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic             out_par,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] done_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH-1:0] res;

  // S2 frees up when empty or draining; S1 can refill whenever S2 takes its beat.
  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Lane-wise logic function selected by the op held in S1.
  always_comb begin
    res = '0;
    case (s1_op)
      3'b000:  res = s1_a & s1_b;
      3'b001:  res = s1_a | s1_b;
      3'b010:  res = ~(s1_a & s1_b);
      3'b011:  res = ~(s1_a | s1_b);
      3'b100:  res = s1_a ^ s1_b;
      3'b101:  res = ~(s1_a ^ s1_b);
      3'b110:  res = ~s1_a;
      default: res = s1_a;
    endcase
  end

  // Stage 1: operand capture. The valid bit follows in_valid on every advance,
  // so it clears when S1 hands its beat on and nothing new arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_op;
      end
    end
  end

  // Stage 2: result register. Nothing changes while stalled, which keeps the
  // presented beat stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b1;
      out_par   <= 1'b0;
      out_op    <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y    <= res;
        out_zero <= (res == '0);
        out_par  <= ^res;
        out_op   <= s1_op;
      end
    end
  end

  // Completed-result counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_valid && out_ready) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed scenarios followed by random traffic.
// Expected results are queued at input acceptance and checked by a monitor
// on each output transfer. A second instance with a 2-bit counter shares the
// stimulus so that counter wrap is observed.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
    logic [2:0] op;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_op = '0;
  logic       out_ready = 1'b0;

  logic        in_ready, out_valid, out_zero, out_par;
  logic [7:0]  out_y;
  logic [2:0]  out_op;
  logic [15:0] done_cnt;

  logic        in_ready2, out_valid2, out_zero2, out_par2;
  logic [7:0]  out_y2;
  logic [2:0]  out_op2;
  logic [1:0]  done_cnt2;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_par(out_par), .out_op(out_op), .done_cnt(done_cnt)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid2),
    .out_ready(out_ready), .out_y(out_y2), .out_zero(out_zero2),
    .out_par(out_par2), .out_op(out_op2), .done_cnt(done_cnt2)
  );

  // Reference: plain per-op formula, parity by counting set bits.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    int   ones;
    case (op)
      3'd0:    e.y = a & b;
      3'd1:    e.y = a | b;
      3'd2:    e.y = 8'hFF - (a & b);
      3'd3:    e.y = 8'hFF - (a | b);
      3'd4:    e.y = a ^ b;
      3'd5:    e.y = 8'hFF - (a ^ b);
      3'd6:    e.y = 8'hFF - a;
      default: e.y = a;
    endcase
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(e.y[i]);
    e.z  = (e.y == 8'h00);
    e.p  = (ones % 2) == 1;
    e.op = op;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] op, input logic ordy, output logic acc);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    #1;
    acc = v && in_ready && rst_n;
    if (acc) exp_q.push_back(model(a, b, op));
    @(posedge clk);
    #1;
  endtask

  // Monitor: counter tracking, stall stability, and in-order result checks.
  logic stall_prev = 1'b0;
  exp_t held;
  exp_t got;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      chk("done_cnt", 32'(done_cnt), 32'(n_out & 32'hFFFF));
      chk("done_cnt_w2", 32'(done_cnt2), 32'(n_out % 4));
      if (stall_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_y", 32'(out_y), 32'(held.y));
        chk("hold_flags", {out_zero, out_par, out_op}, {held.z, held.p, held.op});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none t=%0t", out_y, $time);
        end else begin
          held = exp_q.pop_front();
          got  = '{y: out_y, z: out_zero, p: out_par, op: out_op};
          chk("beat", 32'(got), 32'(held));
          chk("beat_w2", {out_valid2, out_y2, out_zero2, out_par2, out_op2},
              {1'b1, held.y, held.z, held.p, held.op});
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      held       = '{y: out_y, z: out_zero, p: out_par, op: out_op};
    end
  end

  logic [7:0] sweep_y [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};

  initial begin
    logic acc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_flags", {out_zero, out_par, out_op}, {1'b1, 1'b0, 3'd0});
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

    // Single beat with latency
    step(1'b1, 8'hF0, 8'h3C, 3'd0, 1'b1, acc);
    chk("single_acc", 32'(acc), 32'd1);
    chk("single_lat1_valid", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("single_lat2_valid", 32'(out_valid), 32'd1);
    chk("single_y", 32'(out_y), 32'h30);
    chk("single_flags", {out_zero, out_par}, 2'b00);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("single_done_cnt", 32'(done_cnt), 32'd1);

    // All-ops sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b1, acc);
      chk("sweep_acc", 32'(acc), 32'd1);
      if (i > 0) begin
        chk("sweep_valid", 32'(out_valid), 32'd1);
        chk("sweep_y", 32'(out_y), 32'(sweep_y[i-1]));
        chk("sweep_op", 32'(out_op), 32'(i - 1));
      end
    end
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("sweep_last_y", 32'(out_y), 32'hA5);
    chk("sweep_last_op", 32'(out_op), 32'd7);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

    // Backpressure: two accepted, third held off until release
    step(1'b1, 8'h11, 8'h22, 3'd1, 1'b0, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    step(1'b1, 8'h33, 8'h44, 3'd2, 1'b0, acc);
    chk("bp_acc2", 32'(acc), 32'd1);
    step(1'b1, 8'h55, 8'h66, 3'd4, 1'b0, acc);
    chk("bp_acc3_blocked", 32'(acc), 32'd0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'h55, 8'h66, 3'd4, 1'b0, acc);
    chk("bp_acc3_blocked2", 32'(acc), 32'd0);
    chk("bp_first_held", 32'(out_y), 32'h33);
    step(1'b1, 8'h55, 8'h66, 3'd4, 1'b1, acc);
    chk("bp_acc3_release", 32'(acc), 32'd1);
    repeat (3) step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Zero and parity flags
    step(1'b1, 8'hFF, 8'hFF, 3'd4, 1'b1, acc);
    step(1'b1, 8'h07, 8'h00, 3'd7, 1'b1, acc);
    chk("zp_y0", 32'(out_y), 32'h00);
    chk("zp_flags0", {out_zero, out_par}, 2'b10);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("zp_y1", 32'(out_y), 32'h07);
    chk("zp_flags1", {out_zero, out_par}, 2'b01);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 8'($urandom), 8'($urandom), 3'($urandom),
           ($urandom_range(0, 9) < 7), acc);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++)
      step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream: two beats in flight are discarded
    step(1'b1, 8'h12, 8'h34, 3'd1, 1'b0, acc);
    step(1'b1, 8'h56, 8'h78, 3'd0, 1'b0, acc);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("mid_rst_done_cnt_w2", 32'(done_cnt2), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    n_out = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("post_rst_empty", 32'(out_valid), 32'd0);
    step(1'b1, 8'hC3, 8'h3C, 3'd5, 1'b1, acc);
    chk("post_rst_acc", 32'(acc), 32'd1);
    chk("post_rst_lat1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("post_rst_lat2", 32'(out_valid), 32'd1);
    chk("post_rst_y", 32'(out_y), 32'h00);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("post_rst_done_cnt", 32'(done_cnt), 32'd1);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
